// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter for a single-port synchronous-read RAM.
// Serialises CPU (m0) and debug/loader (m1) accesses. Each transaction takes one
// ACCESS cycle (RAM samples address/write) and one RESP cycle (ack pulse). Read
// data is captured on the edge that leaves RESP.
//
// Ports:
//   clk, reset            clock (rising edge), synchronous active-high reset
//   m0_cmd/addr/wdata     master 0 request (cmd 01 read, 11 write, x0 idle)
//   m0_rdata, m0_ack      master 0 registered read data, one-cycle completion pulse
//   m1_cmd/addr/wdata     master 1 request, same encoding
//   m1_rdata, m1_ack      master 1 registered read data, one-cycle completion pulse
//   ram_addr/wdata/write  registered RAM control
//   ram_rdata             RAM read data, valid the cycle after the address
//   grant                 one-hot owner of the current transaction, 00 when idle
//   busy                  high in ACCESS and RESP
module mem_arbiter #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        m0_cmd,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    input  logic [1:0]        m1_cmd,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        grant,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // ptr holds the index of the last granted master
    logic ptr;
    logic ptr_nxt;
    // remembers whether the transaction in flight is a write (ram_write drops after ACCESS)
    logic op_write;
    logic op_write_nxt;

    logic              cand0;
    logic              cand1;
    logic              launch;
    logic              win1;
    logic [1:0]        win_cmd;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    logic [ADDR_W-1:0] ram_addr_nxt;
    logic [DATA_W-1:0] ram_wdata_nxt;
    logic              ram_write_nxt;
    logic [1:0]        grant_nxt;
    logic              busy_nxt;
    logic              m0_ack_nxt;
    logic              m1_ack_nxt;
    logic [DATA_W-1:0] m0_rdata_nxt;
    logic [DATA_W-1:0] m1_rdata_nxt;

    // Arbitration: in RESP the owner's held cmd is masked so it is not re-issued
    always_comb begin
        cand0 = 1'b0;
        cand1 = 1'b0;
        case (state)
            IDLE: begin
                cand0 = m0_cmd[0];
                cand1 = m1_cmd[0];
            end
            RESP: begin
                cand0 = m0_cmd[0] & ~grant[0];
                cand1 = m1_cmd[0] & ~grant[1];
            end
            default: begin
                cand0 = 1'b0;
                cand1 = 1'b0;
            end
        endcase
        launch    = cand0 | cand1;
        // on a tie the master other than the last winner gets the grant
        win1      = cand1 & (~cand0 | ~ptr);
        win_cmd   = win1 ? m1_cmd   : m0_cmd;
        win_addr  = win1 ? m1_addr  : m0_addr;
        win_wdata = win1 ? m1_wdata : m0_wdata;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = launch ? ACCESS : IDLE;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = launch ? ACCESS : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        ram_addr_nxt  = ram_addr;
        ram_wdata_nxt = ram_wdata;
        ram_write_nxt = 1'b0;
        grant_nxt     = grant;
        busy_nxt      = busy;
        m0_ack_nxt    = 1'b0;
        m1_ack_nxt    = 1'b0;
        m0_rdata_nxt  = m0_rdata;
        m1_rdata_nxt  = m1_rdata;
        ptr_nxt       = ptr;
        op_write_nxt  = op_write;

        // read data is captured on the edge leaving RESP
        if (state == RESP && !op_write) begin
            if (grant[0]) m0_rdata_nxt = ram_rdata;
            if (grant[1]) m1_rdata_nxt = ram_rdata;
        end

        case (state)
            ACCESS: begin
                busy_nxt   = 1'b1;
                m0_ack_nxt = grant[0];
                m1_ack_nxt = grant[1];
            end
            default: begin
                if (launch) begin
                    ram_addr_nxt  = win_addr;
                    ram_wdata_nxt = win_wdata;
                    ram_write_nxt = (win_cmd == 2'b11);
                    op_write_nxt  = (win_cmd == 2'b11);
                    grant_nxt     = win1 ? 2'b10 : 2'b01;
                    busy_nxt      = 1'b1;
                    ptr_nxt       = win1;
                end else begin
                    grant_nxt = 2'b00;
                    busy_nxt  = 1'b0;
                end
            end
        endcase
    end

    // Output and bookkeeping registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_write <= 1'b0;
            grant     <= 2'b00;
            busy      <= 1'b0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            ptr       <= 1'b1;
            op_write  <= 1'b0;
        end else begin
            ram_addr  <= ram_addr_nxt;
            ram_wdata <= ram_wdata_nxt;
            ram_write <= ram_write_nxt;
            grant     <= grant_nxt;
            busy      <= busy_nxt;
            m0_ack    <= m0_ack_nxt;
            m1_ack    <= m1_ack_nxt;
            m0_rdata  <= m0_rdata_nxt;
            m1_rdata  <= m1_rdata_nxt;
            ptr       <= ptr_nxt;
            op_write  <= op_write_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a synchronous-read RAM model.
// Expected transactions are queued when driven and popped when an ack appears.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              preload;
    logic [1:0]        m0_cmd;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_ack;
    logic [1:0]        m1_cmd;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_ack;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_write;
    logic [DATA_W-1:0] ram_rdata;
    logic [1:0]        grant;
    logic              busy;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_cmd    (m0_cmd),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_rdata  (m0_rdata),
        .m0_ack    (m0_ack),
        .m1_cmd    (m1_cmd),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_rdata  (m1_rdata),
        .m1_ack    (m1_ack),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_write (ram_write),
        .ram_rdata (ram_rdata),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM; preload plants the known word used by the read tests
    logic [DATA_W-1:0] mem [512];
    always @(posedge clk) begin
        if (preload) mem[5] <= 16'hABCD;
        else if (ram_write) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int                master;
        bit                wr;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    logic [DATA_W-1:0] model_mem [512];

    // Monitor: pops the scoreboard on each ack and checks read data one cycle later
    bit                rd_pending = 1'b0;
    int                rd_master  = 0;
    logic [DATA_W-1:0] rd_data;
    bit                prev_write = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            rd_pending = 1'b0;
            prev_write = 1'b0;
        end else begin
            if (rd_pending) begin
                chk(rd_master == 1 ? "m1_rdata" : "m0_rdata",
                    32'(rd_master == 1 ? m1_rdata : m0_rdata), 32'(rd_data));
                rd_pending = 1'b0;
            end
            if (ram_write) chk("ram_write_width", 32'(prev_write), 32'd0);
            prev_write = ram_write;
            if (m0_ack || m1_ack) begin
                chk("ack_exclusive", 32'(m0_ack & m1_ack), 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_master", 32'(m1_ack), 32'(e.master));
                    chk("ack_grant", 32'(grant), (e.master == 1) ? 32'd2 : 32'd1);
                    if (!e.wr) begin
                        rd_pending = 1'b1;
                        rd_master  = e.master;
                        rd_data    = e.data;
                    end
                end
            end
        end
    end

    task automatic push_exp(input int m, input bit wr, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] wd);
        exp_t e;
        e.master = m;
        e.wr     = wr;
        e.data   = wr ? wd : model_mem[a];
        if (wr) model_mem[a] = wd;
        sb.push_back(e);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        sb.delete();
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    // Single transaction from one master; called at a negedge
    task automatic do_txn(input int m, input bit wr, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] wd);
        int wcnt;
        bit got;
        wcnt = 0;
        got  = 1'b0;
        push_exp(m, wr, a, wd);
        if (m == 0) begin
            m0_cmd = wr ? 2'b11 : 2'b01; m0_addr = a; m0_wdata = wd;
        end else begin
            m1_cmd = wr ? 2'b11 : 2'b01; m1_addr = a; m1_wdata = wd;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ram_write) begin
                wcnt++;
                chk("txn_ram_addr", 32'(ram_addr), 32'(a));
                chk("txn_ram_wdata", 32'(ram_wdata), 32'(wd));
            end
            if ((m == 0) ? m0_ack : m1_ack) got = 1'b1;
        end
        chk("txn_ack_seen", 32'(got), 32'd1);
        chk("txn_write_pulses", 32'(wcnt), wr ? 32'd1 : 32'd0);
        if (m == 0) m0_cmd = 2'b00;
        else        m1_cmd = 2'b00;
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        int nack;
        int last;
        bit got;

        reset    = 1'b1;
        preload  = 1'b1;
        m0_cmd   = 2'b00; m0_addr = '0; m0_wdata = '0;
        m1_cmd   = 2'b00; m1_addr = '0; m1_wdata = '0;
        for (int i = 0; i < 512; i++) model_mem[i] = '0;
        model_mem[5] = 16'hABCD;

        // 1: reset and idle
        @(negedge clk);
        preload = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t1_grant", 32'(grant), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_ram_write", 32'(ram_write), 32'd0);
        chk("t1_m0_rdata", 32'(m0_rdata), 32'd0);
        chk("t1_m1_rdata", 32'(m1_rdata), 32'd0);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (m0_ack || m1_ack) cnt++;
        end
        chk("t1_no_ack", 32'(cnt), 32'd0);

        // 2: m0 read of 0x005 with exact latency
        push_exp(0, 1'b0, 9'h005, 16'h0000);
        m0_cmd = 2'b01; m0_addr = 9'h005;
        @(negedge clk);
        chk("t2_ram_addr", 32'(ram_addr), 32'h005);
        chk("t2_ram_write", 32'(ram_write), 32'd0);
        chk("t2_grant", 32'(grant), 32'd1);
        chk("t2_busy", 32'(busy), 32'd1);
        chk("t2_ack_early", 32'(m0_ack), 32'd0);
        @(negedge clk);
        chk("t2_m0_ack", 32'(m0_ack), 32'd1);
        chk("t2_m1_ack", 32'(m1_ack), 32'd0);
        m0_cmd = 2'b00;
        @(negedge clk);
        chk("t2_ack_pulse", 32'(m0_ack), 32'd0);
        @(negedge clk);
        chk("t2_m0_rdata_hold", 32'(m0_rdata), 32'hABCD);

        // 3: m1 write then m0 read-back
        do_txn(1, 1'b1, 9'h1F0, 16'h1234);
        do_txn(0, 1'b0, 9'h1F0, 16'h0000);
        chk("t3_m1_rdata_unchanged", 32'(m1_rdata), 32'd0);

        // 4: continuous contention from reset
        do_reset(2);
        push_exp(0, 1'b0, 9'h005, 16'h0000);
        push_exp(1, 1'b0, 9'h1F0, 16'h0000);
        push_exp(0, 1'b0, 9'h005, 16'h0000);
        push_exp(1, 1'b0, 9'h1F0, 16'h0000);
        push_exp(0, 1'b0, 9'h005, 16'h0000);
        m0_cmd = 2'b01; m0_addr = 9'h005;
        m1_cmd = 2'b01; m1_addr = 9'h1F0;
        nack = 0;
        last = 0;
        for (int i = 0; i < 40 && nack < 5; i++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                nack++;
                if (nack > 1) chk("t4_ack_gap", 32'(cyc - last), 32'd2);
                last = cyc;
                if (nack == 4) m1_cmd = 2'b00;
                if (nack == 5) m0_cmd = 2'b00;
            end
        end
        chk("t4_ack_count", 32'(nack), 32'd5);
        repeat (2) @(negedge clk);
        chk("t4_idle_after", 32'(busy), 32'd0);

        // 5: reset during ACCESS of an m0 write
        m0_cmd = 2'b11; m0_addr = 9'h0AA; m0_wdata = 16'h5555;
        @(negedge clk);
        chk("t5_access_busy", 32'(busy), 32'd1);
        chk("t5_access_write", 32'(ram_write), 32'd1);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("t5_rst_write", 32'(ram_write), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_ack", 32'(m0_ack), 32'd0);
        chk("t5_rst_grant", 32'(grant), 32'd0);
        reset = 1'b0;
        push_exp(0, 1'b1, 9'h0AA, 16'h5555);
        cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            cnt++;
            if (m0_ack) got = 1'b1;
        end
        chk("t5_ack_latency", 32'(cnt), 32'd2);
        m0_cmd = 2'b00;
        @(negedge clk);
        do_txn(0, 1'b0, 9'h0AA, 16'h0000);

        // 6: non-request commands
        m0_cmd = 2'b10;
        m1_cmd = 2'b00;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (grant != 2'b00 || ram_write || m0_ack || m1_ack || busy) cnt++;
        end
        chk("t6_no_activity", 32'(cnt), 32'd0);
        m0_cmd = 2'b00;
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master arbiter for the single-port, synchronous-read data/instruction RAM (9-bit word address, 16-bit data).
- Master 0 is the CPU memory port. Master 1 is the debug/program loader port.
- Serialises accesses, applies round-robin fairness, drives the RAM control signals and returns registered read data with a one-cycle ack pulse per transaction.

Parameters:
ADDR_W, 9, RAM word-address width
DATA_W, 16, data width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
m0_cmd  in  2  master 0 command: 2'b01 read, 2'b11 write, 2'b00/2'b10 no request
m0_addr  in  ADDR_W  master 0 address
m0_wdata  in  DATA_W  master 0 write data
m0_rdata  out  DATA_W  master 0 read data, registered
m0_ack  out  1  master 0 transaction complete, one-cycle pulse
m1_cmd  in  2  master 1 command, same encoding as m0_cmd
m1_addr  in  ADDR_W  master 1 address
m1_wdata  in  DATA_W  master 1 write data
m1_rdata  out  DATA_W  master 1 read data, registered
m1_ack  out  1  master 1 transaction complete, one-cycle pulse
ram_addr  out  ADDR_W  RAM address, registered
ram_wdata  out  DATA_W  RAM write data, registered
ram_write  out  1  RAM write enable, registered
ram_rdata  in  DATA_W  RAM read data, valid the cycle after the address is presented
grant  out  2  one-hot owner of the current transaction (bit0 = m0); 2'b00 when idle
busy  out  1  high in ACCESS and RESP

Behaviour:
- Reset (synchronous, active-high, clk rising edge):
  - state = IDLE, last-granted pointer = 1 (so m0 wins the first tie).
  - All outputs 0, including m0_rdata and m1_rdata.
- Request rule:
  - A master requests while its cmd is 01 or 11.
  - It must hold cmd, addr and wdata stable until its ack. Changing them earlier is undefined.
  - Commands 00 and 10 are never requests.
- Arbitration (evaluated in IDLE and in RESP):
  - One requester: that master wins.
  - Both requesting: the master not equal to the last-granted pointer wins.
  - The pointer updates to the winner on every grant.
- State machine, 3 states:
  - IDLE
    - No request: stay, grant = 00.
    - Request present: go to ACCESS.
    - On the same edge, load ram_addr/ram_wdata from the winner, set ram_write = (winner cmd == 11), set grant to the winner.
  - ACCESS (exactly 1 cycle)
    - RAM samples addr/write this cycle.
    - Always go to RESP.
    - On exit, ram_write clears to 0.
  - RESP (1 cycle)
    - ack of the owner = 1.
    - For reads, owner rdata <= ram_rdata on the edge that leaves RESP, so rdata is valid the cycle after ack.
    - Writes leave rdata unchanged.
    - Next state:
      - A request other than the owner's just-acked one is pending: go directly to ACCESS, loading RAM registers as in IDLE.
      - Otherwise: go to IDLE.
    - The just-acked master's cmd is ignored in this cycle, so a held cmd is not re-issued.
- Latency and throughput:
  - cmd first sampled in IDLE at edge T: ram_* valid T..T+1, ack high in cycle T+1..T+2, rdata valid from T+2.
  - Under continuous contention: one transaction per 2 cycles, strictly alternating m0/m1.
- Output timing:
  - ack is high only in RESP, exactly one cycle per transaction.
  - m0_ack and m1_ack are never high together.
  - ram_write is high only in ACCESS, never for more than one cycle per transaction.
- Idle outputs: ram_addr and ram_wdata hold their last values in IDLE; ram_write = 0.
- Reset mid-operation:
  - Takes priority over everything.
  - The transaction is aborted with no ack; ram_write is 0 after the reset edge.
  - A write already in ACCESS on that edge may or may not have committed; masters must re-issue.
  - A request still held after reset release is served as new.
- Back-to-back from one master: after its ack it must drop cmd for at least one cycle, or it is re-served as a new transaction.

Test Plan:
1. Reset for 2 cycles, then release with both cmd = 00 -> grant = 00, busy = 0, ram_write = 0, both rdata = 0x0000, no ack for 10 cycles.
2. RAM model holds 0xABCD at 0x005; m0_cmd = 01, m0_addr = 0x005 sampled at edge T -> ram_addr = 0x005 and ram_write = 0 at T, m0_ack high for cycle T+1 only, m0_rdata = 0xABCD from T+2, m1_ack never high.
3. m1 write of 0x1234 to 0x1F0 -> ram_write high exactly one cycle with ram_addr = 0x1F0 and ram_wdata = 0x1234, then m1_ack. A following m0 read of 0x1F0 returns 0x1234 and m1_rdata is unchanged.
4. Both masters request reads from reset, held continuously and re-issued after each ack -> order m0, m1, m0, m1, acks every 2 cycles, grant alternating 01/10.
5. reset asserted during ACCESS of an m0 write -> ram_write = 0 and busy = 0 after that edge, no m0_ack. The m0 request still held after reset release is served with its ack 2 cycles later.
6. m0_cmd = 10 and m1_cmd = 00 for 8 cycles -> no grant, no RAM write, no ack.
